// File: rtl/activity_led_scheduler.sv
// Shares one activity LED between four event sources; source i blinks i+1 pulses.
// Define ACTIVITY_LED_FIXED_PRIORITY_EN for fixed priority (source 0 highest) instead of round-robin.
module activity_led_scheduler #(
   parameter int TIMER_BITS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] events,
   output logic       led,
   output logic       busy,
   output logic [1:0] active_src,
   output logic [3:0] pending
);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF,
      GAP
   } state_t;

   localparam logic [TIMER_BITS:0] PHASE_END = {1'b0, {TIMER_BITS{1'b1}}};
   localparam logic [TIMER_BITS:0] GAP_END   = {(TIMER_BITS + 1){1'b1}};
   localparam logic [TIMER_BITS:0] TIMER_ONE = (TIMER_BITS + 1)'(1);

   state_t              state;
   state_t              state_d;
   logic [3:0]          sync1;
   logic [3:0]          sync2;
   logic [3:0]          sync3;
   logic [3:0]          edges;
   logic [3:0]          clr;
   logic [TIMER_BITS:0] timer;
   logic [TIMER_BITS:0] timer_d;
   logic [1:0]          blink_left;
   logic [1:0]          blink_d;
   logic [1:0]          src_d;
   logic [1:0]          grant_idx;
   logic                led_d;
   logic                take;

   assign edges = sync2 & ~sync3;

   // Event input path: two-flop synchronizer plus one flop for edge detect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= events;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // A new edge on the grant cycle wins over the clear, so it replays later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | edges;
      end
   end

`ifdef ACTIVITY_LED_FIXED_PRIORITY_EN
   always_comb begin
      grant_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (pending[k]) begin
            grant_idx = 2'(k);
         end
      end
   end
`else
   logic [1:0] last_grant;
   logic [1:0] cand;

   // Smallest offset from last_grant wins; offset 4 revisits last_grant itself
   always_comb begin
      grant_idx = last_grant;
      cand      = last_grant;
      for (int k = 4; k >= 1; k--) begin
         cand = last_grant + 2'(k);
         if (pending[cand]) begin
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 2'd3;
      end else if (take) begin
         last_grant <= grant_idx;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      timer_d = timer + TIMER_ONE;
      blink_d = blink_left;
      src_d   = active_src;
      led_d   = led;
      clr     = '0;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            timer_d = timer;
            if (|pending) begin
               take           = 1'b1;
               clr[grant_idx] = 1'b1;
               src_d          = grant_idx;
               blink_d        = grant_idx;
               timer_d        = '0;
               led_d          = 1'b1;
               state_d        = ON;
            end
         end
         ON: begin
            if (timer == PHASE_END) begin
               timer_d = '0;
               led_d   = 1'b0;
               if (blink_left == 2'd0) begin
                  state_d = GAP;
               end else begin
                  blink_d = blink_left - 2'd1;
                  state_d = OFF;
               end
            end
         end
         OFF: begin
            if (timer == PHASE_END) begin
               timer_d = '0;
               led_d   = 1'b1;
               state_d = ON;
            end
         end
         GAP: begin
            if (timer == GAP_END) begin
               timer_d = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer      <= '0;
         blink_left <= '0;
         active_src <= '0;
         led        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         timer      <= timer_d;
         blink_left <= blink_d;
         active_src <= src_d;
         led        <= led_d;
         busy       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_activity_led_scheduler.sv
// Randomized scoreboard bench for activity_led_scheduler (TIMER_BITS=3).
// A timing-level model predicts each blink code; a monitor checks every code the DUT plays.
module tb_activity_led_scheduler;

   localparam int TB_BITS = 3;
   localparam int PH      = 1 << TB_BITS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] events = 4'b0000;
   logic       led;
   logic       busy;
   logic [1:0] active_src;
   logic [3:0] pending;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int         src;
      int         edge_n;
      logic [3:0] pend;
      int         dur;
   } code_t;

   code_t expq[$];

   always #5 clk = ~clk;

   activity_led_scheduler #(.TIMER_BITS(TB_BITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .events    (events),
      .led       (led),
      .busy      (busy),
      .active_src(active_src),
      .pending   (pending)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [3:0] p, input int last);
`ifdef ACTIVITY_LED_FIXED_PRIORITY_EN
      for (int i = 0; i < 4; i++) if (p[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (p[(last + k) % 4]) return (last + k) % 4;
`endif
      return 0;
   endfunction

   // Reference model: rising edge seen at edge n becomes pending at edge n+2;
   // an idle scheduler grants at the next edge and stays busy (2i+1)*PH + 2*PH cycles.
   logic [3:0] m_prev = '0;
   logic [3:0] m_st1 = '0;
   logic [3:0] m_st2 = '0;
   logic [3:0] m_pend = '0;
   int         m_last = 3;
   int         m_free = 0;

   always @(posedge clk) begin
      logic [3:0] rise;
      logic [3:0] set_now;
      logic [3:0] mclr;
      int         g;
      code_t      c;
      cyc++;
      if (reset) begin
         m_prev = '0;
         m_st1  = '0;
         m_st2  = '0;
         m_pend = '0;
         m_last = 3;
         m_free = 0;
         expq.delete();
      end else begin
         rise    = events & ~m_prev;
         m_prev  = events;
         set_now = m_st2;
         m_st2   = m_st1;
         m_st1   = rise;
         mclr    = '0;
         if (cyc >= m_free && m_pend != 4'b0000) begin
            g       = pick(m_pend, m_last);
            mclr[g] = 1'b1;
            m_last  = g;
            c.src    = g;
            c.edge_n = cyc;
            c.pend   = (m_pend & ~mclr) | set_now;
            c.dur    = (2 * g + 1) * PH + 2 * PH;
            expq.push_back(c);
            m_free = cyc + c.dur + 1;
         end
         m_pend = (m_pend & ~mclr) | set_now;
      end
   end

   // Monitor: a code starts when busy rises and is scored when busy falls
   int    trk = 0;
   int    mcnt = 0;
   int    mpulse = 0;
   logic  prev_led = 1'b0;
   code_t cur;

   always @(negedge clk) begin
      if (reset) begin
         trk      = 0;
         prev_led = 1'b0;
      end else begin
         if (trk == 0 && busy) begin
            if (expq.size() == 0) begin
               chk("unexpected_code", int'(active_src), -1);
               cur.src = -1;
               cur.dur = -1;
            end else begin
               cur = expq.pop_front();
               chk("grant_src", int'(active_src), cur.src);
               chk("grant_edge", cyc, cur.edge_n);
               chk("pend_at_grant", int'(pending), int'(cur.pend));
               chk("led_first", int'(led), 1);
            end
            trk    = 1;
            mcnt   = 1;
            mpulse = led ? 1 : 0;
         end else if (trk != 0 && busy) begin
            mcnt++;
            if (led && !prev_led) mpulse++;
         end else if (trk != 0 && !busy) begin
            chk("busy_len", mcnt, cur.dur);
            chk("pulses", mpulse, cur.src + 1);
            chk("led_idle", int'(led), 0);
            trk = 0;
         end
         prev_led = led;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tick(2);
      #2 reset = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] v);
      events = v;
      tick(1);
      events = 4'b0000;
   endtask

   task automatic wait_idle(input int limit);
      bit done = 1'b0;
      tick(4);
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         if (!busy && pending == 4'b0000 && expq.size() == 0) done = 1'b1;
      end
      chk("idle_reached", int'(done), 1);
   endtask

   initial begin
      bit seen;
      tick(3);
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_src", int'(active_src), 0);
      chk("rst_pend", int'(pending), 0);
      #2 reset = 1'b0;

      // single event on source 2, held four edges
      @(negedge clk);
      events = 4'b0100;
      repeat (3) @(posedge clk);
      #1;
      chk("pend2_visible", int'(pending), 4'b0100);
      chk("led_not_yet", int'(led), 0);
      @(posedge clk);
      #1;
      chk("led_latency", int'(led), 1);
      @(negedge clk);
      events = 4'b0000;
      wait_idle(200);
      chk("src_after2", int'(active_src), 2);
      chk("pend_after2", int'(pending), 0);

      // level held high counts once
      events = 4'b0001;
      tick(200);
      events = 4'b0000;
      wait_idle(200);

      // all four together after reset: 0,1,2,3
      do_reset();
      pulse(4'b1111);
      wait_idle(600);

      // reset in the middle of source 3's code
      do_reset();
      pulse(4'b1000);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("src3_started", int'(seen), 1);
      pulse(4'b0010);
      tick(3);
      #2 reset = 1'b1;
      #1;
      chk("amid_led", int'(led), 0);
      chk("amid_busy", int'(busy), 0);
      chk("amid_pend", int'(pending), 0);
      chk("amid_src", int'(active_src), 0);
      tick(2);
      #2 reset = 1'b0;
      pulse(4'b0001);
      wait_idle(200);

      // fairness: source 0 re-pulsed while source 1 waits
      do_reset();
      pulse(4'b0011);
      for (int i = 0; i < 3; i++) begin
         tick(15);
         pulse(4'b0001);
      end
      wait_idle(600);

      // new edge on source 1 exactly at its own grant edge
      do_reset();
      pulse(4'b0011);
      tick(24);
      pulse(4'b0010);
      wait_idle(400);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) events[$urandom_range(0, 3)] ^= 1'b1;
      end
      events = 4'b0000;
      wait_idle(1500);
      chk("queue_empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/activity_led_scheduler.md
Name: activity_led_scheduler

Overview:
- Shares one front-panel activity LED between four asynchronous event sources, e.g. SPI command, read, write and host-reset strobes.
- Synchronizes each event, detects its rising edge and latches it as pending.
- Round-robin arbitration picks one pending source at a time and plays a blink code on the LED: source i produces i+1 pulses.
- Sits between event strobes from other clock domains and the board LED pin. It replaces per-source pulse stretchers.

Parameters:
- TIMER_BITS, 20: phase timer width. One blink ON phase and one OFF phase each last 2^TIMER_BITS cycles. The inter-code GAP lasts 2^(TIMER_BITS+1) cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- events  input  4  asynchronous event strobes, level-sampled, rising edge counts
- led  output  1  LED drive, 1 = lit
- busy  output  1  high while a blink code is in progress (state != IDLE)
- active_src  output  2  index of the source being played; holds the last granted index while IDLE
- pending  output  4  latched, not-yet-serviced events

Behaviour:
- Reset (asynchronous, active-high) clears:
  - sync/edge flops, pending, timer, blink counter
  - led=0, busy=0, active_src=0, state=IDLE
  - last_grant=3, so source 0 has first priority after reset.
- Input path, per bit: two-flop synchronizer, then a third flop for edge detect.
  - If edge k is the first to sample events[i]=1, pending[i] is 1 after edge k+2.
  - A level held high counts once.
  - Repeated edges while pending[i]=1 merge; no count is kept.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - If pending!=0, grant the first set bit searching last_grant+1, +2, +3, +4 (mod 4).
  - On the grant edge: clear that pending bit, set active_src and last_grant, blink_left=index, timer=0, state=ON.
  - Minimum event-to-LED latency: led=1 after edge k+3.
- ON: led=1.
  - Timer increments each cycle.
  - At timer all-ones: timer wraps to 0.
  - If blink_left==0, go to GAP; else decrement blink_left and go to OFF.
- OFF: led=0 for 2^TIMER_BITS cycles, then ON.
- GAP: led=0 for 2^(TIMER_BITS+1) cycles, using one extra timer bit, then IDLE.
  - GAP guarantees separable codes.
- Simultaneous set and clear of the same pending bit (a new edge on the grant cycle): set wins, so the event is replayed later.
- Events arriving during ON/OFF/GAP only set pending bits. They never interrupt the code in progress.
- Total busy time for source i, in cycles: (2i+1)·2^TIMER_BITS + 2^(TIMER_BITS+1).
- Reset mid-code: LED off immediately (asynchronous). All pending events are dropped.
- Outputs are registered, with no combinational path from events to any output.

Optional Feature:
- Macro ACTIVITY_LED_FIXED_PRIORITY_EN.
- Defined: arbitration is fixed priority with 0 highest, regardless of last_grant. last_grant logic is removed.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan (TIMER_BITS=3):
- Reset asserted mid-ON, during source 3's code -> led, busy, pending, active_src all 0 asynchronously. After release, events=0001 yields a source-0 code (1 pulse) first.
- Single pulse on events[2] at edge 0, held 4 cycles -> pending[2] visible after edge 2, led=1 after edge 3. LED sequence is 8 on, 8 off, 8 on, 8 off, 8 on, then 16 gap. busy is high for exactly 56 cycles. active_src=2, pending=0 at end.
- events[0] held high for 200 cycles -> exactly one code (one 8-cycle pulse, busy 24 cycles). No retrigger while the level stays high.
- events=1111 pulsed together after reset -> codes play in order 0,1,2,3 (1,2,3,4 pulses). pending steps 1111→1110→1100→1000→0000 on the grant edges.
- Round-robin fairness: events[0] re-pulsed during every code while events[1] is pending -> grants alternate 0,1,0. With ACTIVITY_LED_FIXED_PRIORITY_EN defined, the same stimulus gives 0,0,0 while source 1 starves.
- events[1] edge landing exactly on its own grant cycle -> pending[1] remains 1. Source 1's code plays twice in succession, separated by a 16-cycle gap.
